hour_units_counter: RTL and testbench
=====================================

Name: hour_units_counter

Overview:
BCD units-of-hours digit (0-9) for the 24 h alarm-clock time chain. It sits directly upstream of the 2-bit hours-tens counter (0-3). It consumes the minutes carry and produces the tens digit's Up pulse and its active-low clear pulse, giving a 23:xx -> 00:xx wrap. It also provides a manual hour-advance button input with hold-to-auto-repeat for time setting.

Parameters:
HOLD_CYCLES, 16, cycles a held button must stay high after the first advance before auto-repeat starts (>=1)
REPEAT_CYCLES, 4, cycles between auto-repeat advances (>=1)
TMR_W, 8, width of the repeat timer; must hold max(HOLD_CYCLES, REPEAT_CYCLES)-1

Ports:
Clk  input  1  clock, rising edge
Clr  input  1  asynchronous, active-low reset
Enable  input  1  global enable; when low, LD, Up and button advances are ignored
Up  input  1  advance request, one-cycle pulse (minutes carry)
LD  input  1  synchronous load strobe
IN  input  4  BCD load value
TENS  input  2  current tens-of-hours digit fed back from the downstream counter
BTN  input  1  asynchronous manual-advance button, active-high, pre-debounced
COUNT  output  4  BCD units digit, registered
TENS_UP  output  1  one-cycle pulse; drives the tens counter Up
TENS_CLR_N  output  1  one-cycle active-low pulse; drives the tens counter Clr
DAY_CARRY  output  1  one-cycle pulse on the 23 -> 00 wrap caused by Up (not by the button)
LOAD_ERR  output  1  one-cycle pulse when LD is rejected

Behaviour:
- Reset (Clr low, async): COUNT=0, TENS_UP=0, TENS_CLR_N=1, DAY_CARRY=0, LOAD_ERR=0, button FSM=IDLE, timer=0, sync flops=0. Reset mid-operation aborts any pending pulse.
- All outputs are registered. Pulse outputs are high or low for exactly one cycle, in the cycle after the triggering edge.
- BTN passes through a 2-flop synchronizer (BTN_S) before use.
- adv = Up OR btn_tick. Coincident Up and btn_tick produce a single advance. DAY_CARRY follows Up only.
- Priority per rising edge, only when Enable=1: LD first, then adv.
- LD: the load is valid if IN<=9 and not (TENS>=2 and IN>3).
  - Valid: COUNT<=IN.
  - Invalid: COUNT holds and LOAD_ERR pulses.
  - LD never generates TENS_UP, TENS_CLR_N or DAY_CARRY.
  - A coincident adv is dropped.
- Advance:
  - If TENS>=2 and COUNT>=3 (wrap): COUNT<=0, TENS_CLR_N pulses low, DAY_CARRY pulses if Up=1. TENS_UP stays 0.
  - Else if COUNT>=9: COUNT<=0, TENS_UP pulses.
  - Else: COUNT<=COUNT+1.
  - TENS=3 is treated as 2.
- Enable=0: COUNT holds, no pulses. The button FSM still tracks BTN_S but its ticks are discarded.
- Button FSM, states IDLE / HOLD / REPEAT:
  - IDLE: on a BTN_S rising edge, btn_tick=1, timer<=HOLD_CYCLES-1, go to HOLD.
  - HOLD: if BTN_S=0, go to IDLE. Else if timer==0, btn_tick=1, timer<=REPEAT_CYCLES-1, go to REPEAT. Else timer decrements.
  - REPEAT: if BTN_S=0, go to IDLE. Else if timer==0, btn_tick=1 and timer reloads REPEAT_CYCLES-1. Else timer decrements.
  - btn_tick is combinational from the FSM and is used in the same cycle.
- Tens-counter feedback: TENS is sampled at the edge. The downstream update lands one cycle after TENS_UP, so a back-to-back adv uses the old TENS for one cycle. Upstream Up pulses are at least 2 cycles apart by system contract.

Test Plan:
1. Reset: with COUNT=6 in REPEAT, drive Clr low mid-cycle -> COUNT=0, TENS_CLR_N=1, all pulses 0 immediately. After release, BTN held high -> first tick only after a fresh rising edge.
2. Units rollover: TENS=0, ten Up pulses 3 cycles apart -> COUNT walks 1..9, then 0. TENS_UP high for exactly one cycle after the 10th pulse. DAY_CARRY stays 0.
3. Day wrap: load COUNT=3 with TENS=2, then Up -> COUNT=0, TENS_CLR_N low for one cycle, DAY_CARRY one cycle, TENS_UP=0. Repeat via button -> no DAY_CARRY.
4. Load rules:
   - TENS=2, LD IN=7 -> COUNT holds, LOAD_ERR pulses.
   - TENS=1, LD IN=5 with Up=1 in the same cycle -> COUNT=5, no increment.
   - LD IN=12 -> LOAD_ERR.
5. Auto-repeat with HOLD_CYCLES=4, REPEAT_CYCLES=2, COUNT=0, BTN high for 14 cycles -> advances at sync+0, +4, +6, +8, +10, +12 (COUNT=6). Release -> IDLE, no further advances.
6. Enable=0 while Up and LD pulse and BTN is held -> COUNT unchanged, no pulses. Re-enable while the button is still held -> the repeat cadence resumes from the current FSM timer.

Source files
------------

// File: rtl/hour_units_counter.sv
// BCD units-of-hours digit for a 24 h clock chain, with a manual advance button
// that auto-repeats while held.
module hour_units_counter #(
    parameter int unsigned HOLD_CYCLES   = 16,
    parameter int unsigned REPEAT_CYCLES = 4,
    parameter int unsigned TMR_W         = 8
) (
    input  logic       Clk,
    input  logic       Clr,
    input  logic       Enable,
    input  logic       Up,
    input  logic       LD,
    input  logic [3:0] IN,
    input  logic [1:0] TENS,
    input  logic       BTN,
    output logic [3:0] COUNT,
    output logic       TENS_UP,
    output logic       TENS_CLR_N,
    output logic       DAY_CARRY,
    output logic       LOAD_ERR
);

    localparam int unsigned CNT_W = 4;
    localparam logic [TMR_W-1:0] HOLD_RELOAD   = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0] REPEAT_RELOAD = TMR_W'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } btn_state_t;

    logic             r_btn_meta;
    logic             r_btn_s;
    btn_state_t       r_state;
    btn_state_t       w_state_nxt;
    logic [TMR_W-1:0] r_timer;
    logic [TMR_W-1:0] w_timer_nxt;
    logic             w_btn_tick;

    logic [CNT_W-1:0] r_count;
    logic             r_tens_up;
    logic             r_tens_clr_n;
    logic             r_day_carry;
    logic             r_load_err;

    logic [CNT_W-1:0] w_count_nxt;
    logic             w_tens_up_nxt;
    logic             w_tens_clr_n_nxt;
    logic             w_day_carry_nxt;
    logic             w_load_err_nxt;

    logic             w_tens_hi;
    logic             w_adv;
    logic             w_load_ok;

    // Two-flop synchronizer for the asynchronous button.
    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            r_btn_meta <= 1'b0;
            r_btn_s    <= 1'b0;
        end else begin
            r_btn_meta <= BTN;
            r_btn_s    <= r_btn_meta;
        end
    end

    // Button FSM state and repeat timer.
    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            r_state <= ST_IDLE;
            r_timer <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
        end
    end

    // IDLE is only re-entered with BTN_S low, so BTN_S high in IDLE is a rising edge.
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_btn_tick  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_btn_s) begin
                    w_btn_tick  = 1'b1;
                    w_timer_nxt = HOLD_RELOAD;
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!r_btn_s) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_timer == '0) begin
                    w_btn_tick  = 1'b1;
                    w_timer_nxt = REPEAT_RELOAD;
                    w_state_nxt = ST_REPEAT;
                end else begin
                    w_timer_nxt = r_timer - TMR_W'(1);
                end
            end
            ST_REPEAT: begin
                if (!r_btn_s) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_timer == '0) begin
                    w_btn_tick  = 1'b1;
                    w_timer_nxt = REPEAT_RELOAD;
                end else begin
                    w_timer_nxt = r_timer - TMR_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // A tens digit of 3 behaves like 2: both are in the 20s.
    assign w_tens_hi = (TENS >= 2'd2);
    assign w_adv     = Up | w_btn_tick;
    assign w_load_ok = (IN <= 4'd9) && !(w_tens_hi && (IN > 4'd3));

    // Digit update: load beats advance; pulses default to their idle levels.
    always_comb begin
        w_count_nxt      = r_count;
        w_tens_up_nxt    = 1'b0;
        w_tens_clr_n_nxt = 1'b1;
        w_day_carry_nxt  = 1'b0;
        w_load_err_nxt   = 1'b0;
        if (Enable) begin
            if (LD) begin
                if (w_load_ok) begin
                    w_count_nxt = IN;
                end else begin
                    w_load_err_nxt = 1'b1;
                end
            end else if (w_adv) begin
                if (w_tens_hi && (r_count >= 4'd3)) begin
                    w_count_nxt      = '0;
                    w_tens_clr_n_nxt = 1'b0;
                    w_day_carry_nxt  = Up;
                end else if (r_count >= 4'd9) begin
                    w_count_nxt   = '0;
                    w_tens_up_nxt = 1'b1;
                end else begin
                    w_count_nxt = r_count + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            r_count      <= '0;
            r_tens_up    <= 1'b0;
            r_tens_clr_n <= 1'b1;
            r_day_carry  <= 1'b0;
            r_load_err   <= 1'b0;
        end else begin
            r_count      <= w_count_nxt;
            r_tens_up    <= w_tens_up_nxt;
            r_tens_clr_n <= w_tens_clr_n_nxt;
            r_day_carry  <= w_day_carry_nxt;
            r_load_err   <= w_load_err_nxt;
        end
    end

    assign COUNT      = r_count;
    assign TENS_UP    = r_tens_up;
    assign TENS_CLR_N = r_tens_clr_n;
    assign DAY_CARRY  = r_day_carry;
    assign LOAD_ERR   = r_load_err;

endmodule

// File: tb/tb_hour_units_counter.sv
// Bench for hour_units_counter: hour-arithmetic reference model compared every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_hour_units_counter;

    localparam int unsigned H = 4;
    localparam int unsigned R = 2;

    logic       Clk    = 1'b0;
    logic       Clr    = 1'b0;
    logic       Enable = 1'b0;
    logic       Up     = 1'b0;
    logic       LD     = 1'b0;
    logic [3:0] IN     = 4'd0;
    logic [1:0] TENS   = 2'd0;
    logic       BTN    = 1'b0;
    logic [3:0] COUNT;
    logic       TENS_UP;
    logic       TENS_CLR_N;
    logic       DAY_CARRY;
    logic       LOAD_ERR;

    int n_cmp  = 0;
    int n_bad  = 0;
    bit chk_en = 1'b0;

    hour_units_counter #(
        .HOLD_CYCLES  (H),
        .REPEAT_CYCLES(R),
        .TMR_W        (8)
    ) dut (
        .Clk       (Clk),
        .Clr       (Clr),
        .Enable    (Enable),
        .Up        (Up),
        .LD        (LD),
        .IN        (IN),
        .TENS      (TENS),
        .BTN       (BTN),
        .COUNT     (COUNT),
        .TENS_UP   (TENS_UP),
        .TENS_CLR_N(TENS_CLR_N),
        .DAY_CARRY (DAY_CARRY),
        .LOAD_ERR  (LOAD_ERR)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: hour = 10*tens + units, advanced modulo 24; the button
    // ticks when BTN_S has been high for 0, H, H+R, H+2R, ... cycles.
    int m_count = 0;
    int m_tup   = 0;
    int m_clrn  = 1;
    int m_day   = 0;
    int m_err   = 0;
    int m_meta  = 0;
    int m_bs    = 0;
    int m_age   = 0;

    always @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            m_count = 0; m_tup = 0; m_clrn = 1; m_day = 0; m_err = 0;
            m_meta  = 0; m_bs  = 0; m_age  = 0;
        end else begin
            int  et;
            int  n;
            bit  tick;
            et   = (int'(TENS) >= 2) ? 2 : int'(TENS);
            tick = (m_bs == 1) &&
                   ((m_age == 0) || ((m_age >= int'(H)) && (((m_age - int'(H)) % int'(R)) == 0)));
            m_tup = 0; m_clrn = 1; m_day = 0; m_err = 0;
            if (Enable) begin
                if (LD) begin
                    if ((int'(IN) <= 9) && (et * 10 + int'(IN) <= 23)) m_count = int'(IN);
                    else m_err = 1;
                end else if (Up || tick) begin
                    n = et * 10 + m_count + 1;
                    if (n >= 24) begin
                        m_count = 0; m_clrn = 0; m_day = Up ? 1 : 0;
                    end else begin
                        m_count = n % 10;
                        m_tup   = (n % 10 == 0) ? 1 : 0;
                    end
                end
            end
            if (m_meta == 1 && m_bs == 1) m_age++;
            else m_age = 0;
            m_bs   = m_meta;
            m_meta = BTN ? 1 : 0;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge Clk) begin
        if (chk_en) begin
            check("model_count",      int'(COUNT),      m_count);
            check("model_tens_up",    int'(TENS_UP),    m_tup);
            check("model_tens_clr_n", int'(TENS_CLR_N), m_clrn);
            check("model_day_carry",  int'(DAY_CARRY),  m_day);
            check("model_load_err",   int'(LOAD_ERR),   m_err);
        end
    end

    task automatic pulse_up();
        Up = 1'b1;
        @(negedge Clk);
        Up = 1'b0;
    endtask

    task automatic load(input logic [3:0] v);
        LD = 1'b1;
        IN = v;
        @(negedge Clk);
        LD = 1'b0;
    endtask

    int exp5 [20] = '{0, 0, 1, 1, 1, 1, 2, 2, 3, 3, 4, 4, 5, 5, 6, 6, 6, 6, 6, 6};

    initial begin
        Enable = 1'b1;
        repeat (2) @(negedge Clk);
        check("rst_count", int'(COUNT), 0);
        check("rst_clr_n", int'(TENS_CLR_N), 1);
        check("rst_pulses", int'({TENS_UP, DAY_CARRY, LOAD_ERR}), 0);
        Clr    = 1'b1;
        chk_en = 1'b1;
        @(negedge Clk);

        // Units rollover with tens = 0
        TENS = 2'd0;
        for (int i = 1; i <= 10; i++) begin
            pulse_up();
            check("roll_count", int'(COUNT), i % 10);
            check("roll_tens_up", int'(TENS_UP), (i == 10) ? 1 : 0);
            check("roll_day", int'(DAY_CARRY), 0);
            @(negedge Clk);
            check("roll_tens_up_gone", int'(TENS_UP), 0);
            @(negedge Clk);
        end

        // Day wrap via Up, then via button
        TENS = 2'd2;
        load(4'd3);
        check("wrap_load", int'(COUNT), 3);
        @(negedge Clk);
        pulse_up();
        check("wrap_count", int'(COUNT), 0);
        check("wrap_clr_n", int'(TENS_CLR_N), 0);
        check("wrap_day", int'(DAY_CARRY), 1);
        check("wrap_tens_up", int'(TENS_UP), 0);
        @(negedge Clk);
        check("wrap_clr_n_end", int'(TENS_CLR_N), 1);
        check("wrap_day_end", int'(DAY_CARRY), 0);
        load(4'd3);
        BTN = 1'b1;
        repeat (3) @(negedge Clk);
        BTN = 1'b0;
        check("btnwrap_count", int'(COUNT), 0);
        check("btnwrap_clr_n", int'(TENS_CLR_N), 0);
        check("btnwrap_day", int'(DAY_CARRY), 0);
        repeat (6) @(negedge Clk);

        // Load rules
        TENS = 2'd2;
        load(4'd2);
        check("ld_ok", int'(COUNT), 2);
        load(4'd7);
        check("ld_bad_hold", int'(COUNT), 2);
        check("ld_bad_err", int'(LOAD_ERR), 1);
        @(negedge Clk);
        check("ld_err_end", int'(LOAD_ERR), 0);
        TENS = 2'd1;
        Up   = 1'b1;
        load(4'd5);
        Up   = 1'b0;
        check("ld_beats_up", int'(COUNT), 5);
        check("ld_no_tens_up", int'(TENS_UP), 0);
        load(4'd12);
        check("ld_12_err", int'(LOAD_ERR), 1);
        check("ld_12_hold", int'(COUNT), 5);
        TENS = 2'd3;
        load(4'd4);
        check("ld_t3_err", int'(LOAD_ERR), 1);
        load(4'd3);
        check("ld_t3_ok", int'(COUNT), 3);
        @(negedge Clk);
        pulse_up();
        check("t3_wrap_count", int'(COUNT), 0);
        check("t3_wrap_clr_n", int'(TENS_CLR_N), 0);
        check("t3_wrap_day", int'(DAY_CARRY), 1);
        @(negedge Clk);

        // Auto-repeat: ticks at BTN_S ages 0,4,6,8,10,12
        TENS = 2'd0;
        load(4'd0);
        @(negedge Clk);
        BTN = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge Clk);
            check("rep_count", int'(COUNT), exp5[k-1]);
            if (k == 14) BTN = 1'b0;
        end

        // Enable low with Up, LD and button; re-enable mid-hold
        Enable = 1'b0;
        BTN    = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge Clk);
            if (k == 2)  check("dis_up", int'(COUNT), 6);
            if (k == 3)  check("dis_ld_err", int'(LOAD_ERR), 0);
            if (k == 5)  check("dis_btn", int'(COUNT), 6);
            if (k == 9)  check("reen_tick1", int'(COUNT), 7);
            if (k == 11) check("reen_tick2", int'(COUNT), 8);
            if (k == 13) check("reen_tick3", int'(COUNT), 9);
            if (k == 20) check("reen_final", int'(COUNT), 9);
            if (k == 1)  Up = 1'b1;
            if (k == 2)  begin Up = 1'b0; LD = 1'b1; IN = 4'd12; end
            if (k == 3)  LD = 1'b0;
            if (k == 8)  Enable = 1'b1;
            if (k == 11) BTN = 1'b0;
        end

        // Async reset while in REPEAT with COUNT=6
        load(4'd4);
        @(negedge Clk);
        BTN = 1'b1;
        repeat (8) @(negedge Clk);
        check("pre_rst_count", int'(COUNT), 6);
        #2 Clr = 1'b0;
        #1;
        check("async_rst_count", int'(COUNT), 0);
        check("async_rst_clr_n", int'(TENS_CLR_N), 1);
        check("async_rst_pulses", int'({TENS_UP, DAY_CARRY, LOAD_ERR}), 0);
        repeat (2) @(negedge Clk);
        Clr = 1'b1;
        @(negedge Clk);
        check("post_rst_c1", int'(COUNT), 0);
        @(negedge Clk);
        check("post_rst_c2", int'(COUNT), 0);
        @(negedge Clk);
        check("post_rst_first_tick", int'(COUNT), 1);
        BTN = 1'b0;
        repeat (5) @(negedge Clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
